// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: core MMIO port to the UART byte engine.
// The design buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO, and exposes a status word.
module uart_mmio_bridge #(
   parameter int DEPTH = 8
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iMEM,
   input  logic        iRW,
   input  logic [1:0]  iADDR,
   input  logic [31:0] iWDATA,
   output logic [31:0] oRDATA,
   output logic [7:0]  oTX_Byte,
   output logic        oTX_Enable,
   input  logic        iTX_Done,
   input  logic [7:0]  iRX_Byte,
   input  logic        iRX_GotIt
);
   localparam int W = $clog2(DEPTH);
   localparam logic [W:0] FULL = (W+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;
   state_t st_q;
   logic [7:0] tx_mem [DEPTH];
   logic [7:0] rx_mem [DEPTH];
   logic [W-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
   logic [W:0] tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
   logic ovr_q, drop_q, en_q, ovr_d, drop_d;
   logic [7:0] byte_q;
   logic [31:0] rdata_q, rdata_d, status;
   logic wr, rd, stat_wr, tx_wr, tx_full, tx_empty, rx_full, rx_empty;
   logic tx_push, tx_pop, rx_push, rx_pop;
   logic unused_ok;
   assign unused_ok = ^iWDATA[31:8];
   always_comb begin
      wr       = iMEM && !iRW;
      rd       = iMEM && iRW;
      stat_wr  = wr && iADDR == 2'd2;
      tx_wr    = wr && iADDR == 2'd0;
      tx_full  = tx_cnt_q == FULL;
      tx_empty = tx_cnt_q == '0;
      rx_full  = rx_cnt_q == FULL;
      rx_empty = rx_cnt_q == '0;
      tx_pop   = st_q == IDLE && !tx_empty;
      tx_push  = tx_wr && (!tx_full || tx_pop);
      rx_pop   = rd && iADDR == 2'd1 && !rx_empty;
      rx_push  = iRX_GotIt && (!rx_full || rx_pop);
      tx_cnt_d = tx_cnt_q + (W+1)'(tx_push) - (W+1)'(tx_pop);
      rx_cnt_d = rx_cnt_q + (W+1)'(rx_push) - (W+1)'(rx_pop);
      // Set events take priority over a software clear in the same cycle.
      drop_d   = (tx_wr && tx_full && !tx_pop) || (drop_q && !(stat_wr && iWDATA[6]));
      ovr_d    = (iRX_GotIt && rx_full && !rx_pop) || (ovr_q && !(stat_wr && iWDATA[4]));
      status   = {8'b0, 8'(rx_cnt_q), 8'(tx_cnt_q), 1'b0, drop_q, st_q != IDLE, ovr_q,
                  rx_full, rx_empty, tx_empty, tx_full};
      rdata_d  = iADDR == 2'd2 ? status :
                 rx_pop ? {23'b0, 1'b1, rx_mem[rx_rp_q]} : 32'b0;
   end
   always_ff @(posedge iCLK) begin
      if (tx_push) tx_mem[tx_wp_q] <= iWDATA[7:0];
      if (rx_push) rx_mem[rx_wp_q] <= iRX_Byte;
   end
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         st_q     <= IDLE;
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         ovr_q    <= 1'b0;
         drop_q   <= 1'b0;
         en_q     <= 1'b0;
         byte_q   <= 8'b0;
         rdata_q  <= 32'b0;
      end else begin
         tx_wp_q  <= tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
         tx_rp_q  <= tx_pop ? tx_rp_q + 1'b1 : tx_rp_q;
         rx_wp_q  <= rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
         rx_rp_q  <= rx_pop ? rx_rp_q + 1'b1 : rx_rp_q;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         ovr_q    <= ovr_d;
         drop_q   <= drop_d;
         en_q     <= tx_pop;
         if (rd) rdata_q <= rdata_d;
         if (tx_pop) byte_q <= tx_mem[tx_rp_q];
         case (st_q)
            IDLE:    if (tx_pop) st_q <= LOAD;
            LOAD:    st_q <= BUSY;
            default: if (iTX_Done) st_q <= IDLE;
         endcase
      end
   end
   assign oRDATA     = rdata_q;
   assign oTX_Byte   = byte_q;
   assign oTX_Enable = en_q;
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge: directed self-checking bench for uart_mmio_bridge (DEPTH = 8).
module tb_uart_mmio_bridge;
   logic iCLK = 0, iRST = 0, iMEM = 0, iRW = 0, iTX_Done = 0, iRX_GotIt = 0;
   logic [1:0] iADDR = 0;
   logic [31:0] iWDATA = 0;
   logic [7:0] iRX_Byte = 0;
   logic [31:0] oRDATA;
   logic [7:0] oTX_Byte;
   logic oTX_Enable;
   int checks = 0, errors = 0;

   uart_mmio_bridge #(.DEPTH(8)) dut (
      .iCLK(iCLK), .iRST(iRST), .iMEM(iMEM), .iRW(iRW), .iADDR(iADDR),
      .iWDATA(iWDATA), .oRDATA(oRDATA), .oTX_Byte(oTX_Byte),
      .oTX_Enable(oTX_Enable), .iTX_Done(iTX_Done), .iRX_Byte(iRX_Byte),
      .iRX_GotIt(iRX_GotIt)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      iMEM = 1; iRW = 0; iADDR = a; iWDATA = d;
      step();
      iMEM = 0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      iMEM = 1; iRW = 1; iADDR = a;
      step();
      iMEM = 0;
      check(tag, oRDATA, exp);
   endtask

   task automatic done_pulse();
      iTX_Done = 1;
      step();
      iTX_Done = 0;
   endtask

   task automatic rx_push(input logic [7:0] b);
      iRX_GotIt = 1; iRX_Byte = b;
      step();
      iRX_GotIt = 0;
   endtask

   initial begin
      step(); step();
      check("rst_en", {31'b0, oTX_Enable}, 32'h0);
      check("rst_byte", {24'b0, oTX_Byte}, 32'h0);
      check("rst_rdata", oRDATA, 32'h0);
      iRST = 1;
      rd(2'd2, 32'h0000_0006, "rst_status");
      rd(2'd0, 32'h0, "txdata_read");
      rd(2'd3, 32'h0, "addr3_read");
      rd(2'd1, 32'h0, "rx_empty_read");
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd2, 32'h0000_0006, "addr3_write_ignored");
      step(); step();
      check("rdata_hold", oRDATA, 32'h0000_0006);

      // Single byte: enable pulse two edges after the store.
      wr(2'd0, 32'h0000_0041);
      check("tx1_en_early", {31'b0, oTX_Enable}, 32'h0);
      step();
      check("tx1_en", {31'b0, oTX_Enable}, 32'h1);
      check("tx1_byte", {24'b0, oTX_Byte}, 32'h41);
      step();
      check("tx1_en_end", {31'b0, oTX_Enable}, 32'h0);
      rd(2'd2, 32'h0000_0026, "tx1_busy");
      check("tx1_byte_hold", {24'b0, oTX_Byte}, 32'h41);
      done_pulse();
      rd(2'd2, 32'h0000_0006, "tx1_idle");

      // Overfill TX with iTX_Done withheld.
      for (int i = 0; i < 10; i++) wr(2'd0, i);
      rd(2'd2, 32'h0000_0865, "tx_full_status");
      check("tx_busy_byte0", {24'b0, oTX_Byte}, 32'h00);
      for (int k = 1; k <= 8; k++) begin
         done_pulse();
         check($sformatf("drain%0d_en_idle", k), {31'b0, oTX_Enable}, 32'h0);
         step();
         check($sformatf("drain%0d_en", k), {31'b0, oTX_Enable}, 32'h1);
         check($sformatf("drain%0d_byte", k), {24'b0, oTX_Byte}, k);
         step();
      end
      done_pulse();
      rd(2'd2, 32'h0000_0046, "tx_drop_sticky");
      wr(2'd2, 32'h0000_0040);
      rd(2'd2, 32'h0000_0006, "tx_drop_clear");

      // RX ordering and empty read.
      rx_push(8'h5A);
      rx_push(8'hA5);
      rd(2'd1, 32'h0000_015A, "rx_read1");
      rd(2'd1, 32'h0000_01A5, "rx_read2");
      rd(2'd1, 32'h0000_0000, "rx_read3");

      // RX overrun, clear, simultaneous push/pop on full.
      for (int i = 0; i < 8; i++) rx_push(8'h10 + 8'(i));
      rx_push(8'hFF);
      rd(2'd2, 32'h0008_001A, "rx_overrun");
      wr(2'd2, 32'h0000_0010);
      rd(2'd2, 32'h0008_000A, "rx_overrun_clear");
      iRX_GotIt = 1; iRX_Byte = 8'h77;
      rd(2'd1, 32'h0000_0110, "rx_simul_read");
      iRX_GotIt = 0;
      rd(2'd2, 32'h0008_000A, "rx_simul_status");
      for (int i = 1; i < 8; i++) rd(2'd1, 32'h0000_0110 + i, $sformatf("rx_drain%0d", i));
      rd(2'd1, 32'h0000_0177, "rx_drain_last");

      // Reset while BUSY with three bytes queued.
      for (int i = 0; i < 4; i++) wr(2'd0, 32'hA0 + i);
      rd(2'd2, 32'h0000_0324, "busy_queued");
      check("busy_byte", {24'b0, oTX_Byte}, 32'hA0);
      iRST = 0;
      #1;
      check("async_rst_byte", {24'b0, oTX_Byte}, 32'h0);
      check("async_rst_rdata", oRDATA, 32'h0);
      step();
      iRST = 1;
      done_pulse();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("post_rst_en%0d", i), {31'b0, oTX_Enable}, 32'h0);
         step();
      end
      rd(2'd2, 32'h0000_0006, "post_rst_status");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
